uart_rx: RTL and testbench

- Asynchronous serial receiver, 8N1 by default. Samples the incoming line at mid-bit, LSB first.
- Delivers each received character through a one-entry valid/ready output register.
- Flags framing errors and overruns.
- Sits between the board UART pin and the fabric logic. It is the receive end of the team's UART transmitter and uses the same BAUD_DIVIDER clock-per-bit convention.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 28 ++
 rtl/uart_rx.sv | 211 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and sizing helpers.
// Used by both the receiver and the transmitter.
package uart_pkg;

  // PARITY is always present so the state encoding does not
  // depend on whether the parity build option is enabled.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } uart_rx_state_t;

  // Bits needed to hold values 0..max_value (at least 1).
  function automatic int cnt_width(input int max_value);
    return (max_value < 2) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer for asynchronous inputs.
// RESET_VALUE sets the value both flops take during reset.
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two flops in series resolve metastability on d.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RESET_VALUE;
      sync_q <= RESET_VALUE;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling, LSB first, 1-entry output.
// Build option UART_RX_PARITY_EN adds an even-parity bit check.
module uart_rx
  import uart_pkg::*;
#(
  parameter int NUMBER_OF_BITS = 8,
  parameter int BAUD_DIVIDER   = 4
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      rx,
  output logic [NUMBER_OF_BITS-1:0] data,
  output logic                      valid,
  input  logic                      ready,
  output logic                      framing_error,
`ifdef UART_RX_PARITY_EN
  output logic                      overrun,
  output logic                      parity_error
`else
  output logic                      overrun
`endif
);

  localparam int RW = cnt_width(BAUD_DIVIDER - 1);
  localparam int BW = cnt_width(NUMBER_OF_BITS - 1);

  localparam logic [RW-1:0] RATE_HALF =
    RW'(BAUD_DIVIDER / 2 - 1);
  localparam logic [RW-1:0] RATE_FULL =
    RW'(BAUD_DIVIDER - 1);
  localparam logic [BW-1:0] BIT_LAST =
    BW'(NUMBER_OF_BITS - 1);

  logic rx_s;

  uart_rx_state_t state_q, state_d;
  logic [RW-1:0]  rate_q, rate_d;
  logic [BW-1:0]  bit_q, bit_d;

  logic [NUMBER_OF_BITS-1:0] shift_q, shift_d;
  logic [NUMBER_OF_BITS-1:0] data_q, data_d;

  logic valid_q, valid_d;
  logic fe_q, fe_d;
  logic ov_q, ov_d;
  logic deliver;

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d;
  logic pe_q, pe_d;
`endif

  sync_2ff #(
    .RESET_VALUE(1'b1)
  ) u_sync (
    .clock  (clock),
    .reset_n(reset_n),
    .d      (rx),
    .q      (rx_s)
  );

  // Frame FSM: start detect, mid-bit sampling, stop check.
  always_comb begin
    state_d = state_q;
    rate_d  = rate_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    deliver = 1'b0;
    fe_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    pe_d      = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          rate_d  = RATE_HALF;
          state_d = START;
        end
      end
      START: begin
        if (rate_q != '0) begin
          rate_d = rate_q - RW'(1);
        end else if (rx_s) begin
          state_d = IDLE;
        end else begin
          rate_d  = RATE_FULL;
          bit_d   = BIT_LAST;
          state_d = DATA;
        end
      end
      DATA: begin
        if (rate_q != '0) begin
          rate_d = rate_q - RW'(1);
        end else begin
          shift_d = shift_q >> 1;
          shift_d[NUMBER_OF_BITS-1] = rx_s;
          rate_d = RATE_FULL;
          if (bit_q == '0) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q - BW'(1);
          end
        end
      end
      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (rate_q != '0) begin
          rate_d = rate_q - RW'(1);
        end else begin
          par_bad_d = (^shift_q) ^ rx_s;
          pe_d      = (^shift_q) ^ rx_s;
          rate_d    = RATE_FULL;
          state_d   = STOP;
        end
`else
        state_d = IDLE;
`endif
      end
      STOP: begin
        if (rate_q != '0) begin
          rate_d = rate_q - RW'(1);
        end else if (rx_s) begin
`ifdef UART_RX_PARITY_EN
          deliver = !par_bad_q;
`else
          deliver = 1'b1;
`endif
          state_d = IDLE;
        end else begin
          fe_d    = 1'b1;
          state_d = WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output register: accept, replace on handshake, or overrun.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ov_d    = 1'b0;
    if (valid_q && ready) begin
      valid_d = 1'b0;
    end
    if (deliver) begin
      if (!valid_q || ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ov_d = 1'b1;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rate_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rate_q  <= rate_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity result held until the stop bit decides delivery.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      par_bad_q <= 1'b0;
      pe_q      <= 1'b0;
    end else begin
      par_bad_q <= par_bad_d;
      pe_q      <= pe_d;
    end
  end

  assign parity_error = pe_q;
`endif

  assign data          = data_q;
  assign valid         = valid_q;
  assign framing_error = fe_q;
  assign overrun       = ov_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx (8 data bits, divider 4).
// Frames are driven bit by bit; a monitor logs accepted bytes.
module tb_uart_rx;

  localparam int N = 8;
  localparam int B = 4;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         rx = 1'b1;
  logic         ready = 1'b1;
  logic [N-1:0] data;
  logic         valid;
  logic         framing_error;
  logic         overrun;

  int nchk = 0;
  int npass = 0;
  int nfail = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [7:0] log_q[$];

  int base;
  int fe_b;
  int ov_b;

  always #5 clock = ~clock;

  uart_rx #(
    .NUMBER_OF_BITS(N),
    .BAUD_DIVIDER  (B)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .rx           (rx),
    .data         (data),
    .valid        (valid),
    .ready        (ready),
    .framing_error(framing_error),
    .overrun      (overrun)
  );

  always @(negedge clock) begin
    if (valid && ready) log_q.push_back(data);
    if (framing_error) fe_cnt++;
    if (overrun) ov_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time expired, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] logat(input int i);
    if (i < log_q.size()) return log_q[i];
    return 8'hxx;
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bit_time();
    repeat (B) @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] c,
                      input logic stop = 1'b1);
    rx = 1'b0;
    bit_time();
    for (int i = 0; i < 8; i++) begin
      rx = c[i];
      bit_time();
    end
    rx = stop;
    bit_time();
  endtask

  task automatic mark();
    base = log_q.size();
    fe_b = fe_cnt;
    ov_b = ov_cnt;
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("rst_data", 32'(data), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_fe", 32'(framing_error), 32'h0);
    check("rst_ov", 32'(overrun), 32'h0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    idle(5);

    // single frame 0x41
    mark();
    send(8'h41);
    idle(8);
    check("t1_count", 32'(log_q.size() - base), 32'd1);
    check("t1_data", 32'(logat(base)), 32'h41);
    check("t1_fe", 32'(fe_cnt - fe_b), 32'd0);
    check("t1_ov", 32'(ov_cnt - ov_b), 32'd0);
    check("t1_valid", 32'(valid), 32'h0);

    // one-clock glitch
    mark();
    rx = 1'b0;
    @(posedge clock);
    #1;
    rx = 1'b1;
    idle(12);
    check("t2_count", 32'(log_q.size() - base), 32'd0);
    check("t2_fe", 32'(fe_cnt - fe_b), 32'd0);
    check("t2_valid", 32'(valid), 32'h0);

    // framing error then break, then good frame
    mark();
    send(8'h55, 1'b0);
    rx = 1'b0;
    repeat (3) bit_time();
    rx = 1'b1;
    idle(8);
    check("t3_fe", 32'(fe_cnt - fe_b), 32'd1);
    check("t3_nodeliv", 32'(log_q.size() - base), 32'd0);
    send(8'h0F);
    idle(8);
    check("t3_count", 32'(log_q.size() - base), 32'd1);
    check("t3_data", 32'(logat(base)), 32'h0F);
    check("t3_fe2", 32'(fe_cnt - fe_b), 32'd1);
    check("t3_ov", 32'(ov_cnt - ov_b), 32'd0);

    // overrun with ready low
    mark();
    ready = 1'b0;
    send(8'hA5);
    send(8'h3C);
    idle(8);
    check("t4_valid", 32'(valid), 32'h1);
    check("t4_data", 32'(data), 32'hA5);
    check("t4_ov", 32'(ov_cnt - ov_b), 32'd1);
    check("t4_count", 32'(log_q.size() - base), 32'd0);
    ready = 1'b1;
    @(posedge clock);
    #1;
    ready = 1'b0;
    @(negedge clock);
    check("t4_vdrop", 32'(valid), 32'h0);
    check("t4_acc", 32'(logat(base)), 32'hA5);
    check("t4_acc_n", 32'(log_q.size() - base), 32'd1);

    // delivery coincident with a valid && ready cycle
    @(posedge clock);
    #1;
    mark();
    send(8'h77);
    idle(4);
    check("t5_hold", 32'(data), 32'h77);
    fork
      send(8'h88);
      begin
        repeat (40) @(posedge clock);
        #1;
        ready = 1'b1;
        @(posedge clock);
        #1;
        ready = 1'b0;
      end
    join
    @(negedge clock);
    check("t5_valid", 32'(valid), 32'h1);
    check("t5_data", 32'(data), 32'h88);
    check("t5_ov", 32'(ov_cnt - ov_b), 32'd0);
    check("t5_first", 32'(logat(base)), 32'h77);
    ready = 1'b1;
    idle(3);
    check("t5_second", 32'(logat(base + 1)), 32'h88);
    check("t5_vclr", 32'(valid), 32'h0);

    // ten back-to-back frames
    mark();
    for (int i = 0; i < 10; i++) begin
      send(8'(i));
    end
    idle(8);
    check("t6_count", 32'(log_q.size() - base), 32'd10);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t6_data%0d", i),
            32'(logat(base + i)), 32'(i));
    end
    check("t6_fe", 32'(fe_cnt - fe_b), 32'd0);
    check("t6_ov", 32'(ov_cnt - ov_b), 32'd0);

    // reset in the middle of a 0xFF frame
    mark();
    rx = 1'b0;
    bit_time();
    rx = 1'b1;
    bit_time();
    bit_time();
    reset_n = 1'b0;
    @(negedge clock);
    check("t7_rdata", 32'(data), 32'h0);
    check("t7_rvalid", 32'(valid), 32'h0);
    check("t7_rfe", 32'(framing_error), 32'h0);
    check("t7_rov", 32'(overrun), 32'h0);
    idle(3);
    reset_n = 1'b1;
    idle(40);
    check("t7_none", 32'(log_q.size() - base), 32'd0);
    send(8'h12);
    idle(8);
    check("t7_count", 32'(log_q.size() - base), 32'd1);
    check("t7_data", 32'(logat(base)), 32'h12);
    check("t7_fe", 32'(fe_cnt - fe_b), 32'd0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
